// File: rtl/mdu_hilo_ctrl_if.sv
// E-stage MDU request/response bundle.
// The master side drives the op; the slave side returns busy and HI/LO.
interface mdu_hilo_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        mdu_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, mdu_busy, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, mdu_busy, hi, lo
  );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// MDU HI/LO controller: fixed-latency busy counter, commit at count end.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module mdu_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mdu_hilo_ctrl_if.slave   bus
);

  localparam logic [3:0] LP_MC = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DC = 4'(DIV_CYCLES);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic [3:0]  r_cnt;

  logic        w_busy;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_acc;
  logic        w_is_mth;
  logic        w_is_mtl;
  logic        w_signed;
  logic        w_multi;

  logic signed [63:0] w_smul;
  logic [63:0] w_umul;
  logic [63:0] w_prod;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_dz;
  logic        w_ovf;
  logic [63:0] w_div;
  logic [63:0] w_next;

`ifdef MDU_MADD_EN
  logic        w_sub;
  logic [63:0] w_acc;
`endif

  assign w_busy   = (r_cnt != 4'd0);
  assign w_accept = bus.start & ~w_busy;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_is_acc = 1'b0;
    w_is_mth = 1'b0;
    w_is_mtl = 1'b0;
    w_signed = 1'b0;
`ifdef MDU_MADD_EN
    w_sub    = 1'b0;
`endif
    case (bus.op)
      4'd1: begin w_is_mul = 1'b1; w_signed = 1'b1; end
      4'd2: w_is_mul = 1'b1;
      4'd3: begin w_is_div = 1'b1; w_signed = 1'b1; end
      4'd4: w_is_div = 1'b1;
      4'd5: w_is_mth = 1'b1;
      4'd6: w_is_mtl = 1'b1;
`ifdef MDU_MADD_EN
      4'd7: begin w_is_acc = 1'b1; w_signed = 1'b1; end
      4'd8: w_is_acc = 1'b1;
      4'd9: begin
        w_is_acc = 1'b1;
        w_signed = 1'b1;
        w_sub    = 1'b1;
      end
      4'd10: begin w_is_acc = 1'b1; w_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign w_multi = w_is_mul | w_is_div | w_is_acc;

  assign w_smul = $signed({{32{bus.rs_val[31]}}, bus.rs_val})
                * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign w_umul = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
  assign w_prod = w_signed ? w_smul : w_umul;

  assign w_sq  = $signed(bus.rs_val) / $signed(bus.rt_val);
  assign w_sr  = $signed(bus.rs_val) % $signed(bus.rt_val);
  assign w_uq  = bus.rs_val / bus.rt_val;
  assign w_ur  = bus.rs_val % bus.rt_val;
  assign w_dz  = (bus.rt_val == 32'd0);
  assign w_ovf = (bus.rs_val == 32'h8000_0000)
               & (bus.rt_val == 32'hFFFF_FFFF);

  // Zero divisor keeps HI/LO by recommitting them at the end.
  always_comb begin
    w_div = {w_ur, w_uq};
    if (w_dz)
      w_div = {r_hi, r_lo};
    else if (w_signed && w_ovf)
      w_div = {32'd0, 32'h8000_0000};
    else if (w_signed)
      w_div = {w_sr, w_sq};
  end

`ifdef MDU_MADD_EN
  assign w_acc = w_sub ? ({r_hi, r_lo} - w_prod)
                       : ({r_hi, r_lo} + w_prod);
`endif

  always_comb begin
    w_next = w_prod;
    if (w_is_div)
      w_next = w_div;
`ifdef MDU_MADD_EN
    else if (w_is_acc)
      w_next = w_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      if (w_multi) begin
        r_phi <= w_next[63:32];
        r_plo <= w_next[31:0];
        r_cnt <= w_is_div ? LP_DC : LP_MC;
      end
      if (w_is_mth) r_hi <= bus.rs_val;
      if (w_is_mtl) r_lo <= bus.rs_val;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.mdu_busy = w_busy | (bus.start & w_multi);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
// Expected values are hand-computed constants.
module tb_mdu_hilo_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   nb;

  mdu_hilo_ctrl_if bus ();

  mdu_hilo_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] rs,
                       input logic [31:0] rt,
                       input logic mb_exp);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    #1;
    chk("mdu_busy_at_start", 32'(bus.mdu_busy), 32'(mb_exp));
    step();
    bus.start = 1'b0;
    #1;
  endtask

  // Counts busy cycles into nb; bounded so a stuck busy still ends.
  task automatic wait_idle(input string tag, input int exp_n);
    int guard;
    guard = 0;
    while (bus.busy && guard < 40) begin
      chk("mdu_busy_in_flight", 32'(bus.mdu_busy), 32'd1);
      nb++;
      guard++;
      step();
    end
    chk(tag, 32'(nb), 32'(exp_n));
    chk("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    nb    = 0;
    reset = 1'b1;
    bus.start  = 1'b1;
    bus.op     = 4'd1;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    step();
    chk("mdu_busy_in_reset", 32'(bus.mdu_busy), 32'd1);
    bus.start = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);

    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    nb = 0;
    wait_idle("mult_cycles", 5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

    issue(4'd4, 32'd100, 32'd7, 1'b1);
    nb = 0;
    wait_idle("divu_cycles", 10);
    chk("divu_hi", bus.hi, 32'd2);
    chk("divu_lo", bus.lo, 32'd14);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    nb = 0;
    wait_idle("div_cycles", 10);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);

    issue(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_lo", bus.lo, 32'hFFFF_FFFD);

    issue(4'd3, 32'd5, 32'd0, 1'b1);
    nb = 0;
    chk("dz_hold_hi", bus.hi, 32'h0000_1234);
    wait_idle("divz_cycles", 10);
    chk("divz_hi", bus.hi, 32'h0000_1234);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFD);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    nb = 0;
    wait_idle("ovf_cycles", 10);
    chk("ovf_hi", bus.hi, 32'd0);
    chk("ovf_lo", bus.lo, 32'h8000_0000);

    issue(4'd6, 32'h0000_ABCD, 32'd0, 1'b0);
    chk("mtlo_lo", bus.lo, 32'h0000_ABCD);
    chk("mtlo_hi", bus.hi, 32'd0);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    nb = 0;
    wait_idle("multu_cycles", 5);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    issue(4'd1, 32'd3, 32'd4, 1'b1);
    nb = 0;
    bus.start  = 1'b1;
    bus.op     = 4'd1;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ign_mdu_busy", 32'(bus.mdu_busy), 32'd1);
      chk("ign_lo_hold", bus.lo, 32'h0000_0001);
      nb++;
      step();
    end
    bus.start = 1'b0;
    wait_idle("ign_cycles", 5);
    chk("ign_hi", bus.hi, 32'd0);
    chk("ign_lo", bus.lo, 32'd12);
    chk("idle_mdu_busy", 32'(bus.mdu_busy), 32'd0);

    issue(4'd3, 32'd100, 32'd7, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("rst_nocommit_hi", bus.hi, 32'd0);
    chk("rst_nocommit_lo", bus.lo, 32'd0);

    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    issue(4'd8, 32'd1, 32'd1, 1'b1);
    nb = 0;
    wait_idle("maddu_cycles", 5);
    chk("maddu_hi", bus.hi, 32'd1);
    chk("maddu_lo", bus.lo, 32'd0);
`else
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    chk("maddu_off_busy", 32'(bus.busy), 32'd0);
    step();
    chk("maddu_off_hi", bus.hi, 32'd0);
    chk("maddu_off_lo", bus.lo, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
